// File: rtl/morse_symbol_capture_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : morse_symbol_capture_if
//  Purpose  : Character hand-off bus between the Morse capture stage and its
//             decoder/display consumer (valid/ready plus status pulses).
//  Revision : 1.0  initial release
// ============================================================================
interface morse_symbol_capture_if #(
    parameter int MAX_SYMBOLS = 8
);
    localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);

    logic                   char_valid;
    logic                   char_ready;
    logic [MAX_SYMBOLS-1:0] char_bits;
    logic [LEN_W-1:0]       char_len;
    logic                   char_ovf;
    logic                   word_end;
    logic                   drop;

    modport master (
        output char_valid, char_bits, char_len, char_ovf, word_end, drop,
        input  char_ready
    );

    modport slave (
        input  char_valid, char_bits, char_len, char_ovf, word_end, drop,
        output char_ready
    );
endinterface
`default_nettype wire

// File: rtl/morse_symbol_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : morse_symbol_capture
//  Purpose  : Synchronise/debounce a Morse key, classify presses as dot/dash,
//             pack them into characters and hand them off over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module morse_symbol_capture #(
    parameter int MAX_SYMBOLS = 8,
    parameter int DEBOUNCE    = 16,
    parameter int MIN_PRESS   = 64,
    parameter int DASH_MIN    = 2500,
    parameter int CHAR_GAP    = 2500,
    parameter int WORD_GAP    = 6000,
    parameter int CNT_W       = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              button,
    morse_symbol_capture_if.master bus
);
    localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PRESS = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;
    localparam logic [1:0] c_SPACE = 2'd3;

    // Timer holds L-1 on the edge that ends an L-cycle interval.
    localparam logic [DB_W-1:0]  c_DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] c_MIN_M1   = CNT_W'(MIN_PRESS - 1);
    localparam logic [CNT_W-1:0] c_DASH_M1  = CNT_W'(DASH_MIN - 1);
    localparam logic [CNT_W-1:0] c_CHAR_M1  = CNT_W'(CHAR_GAP - 1);
    localparam logic [CNT_W-1:0] c_WORD_M1  = CNT_W'(WORD_GAP - 1);
    localparam logic [LEN_W-1:0] c_LEN_MAX  = LEN_W'(MAX_SYMBOLS);

    logic                   r_sync1, r_sync2, r_key_db;
    logic [DB_W-1:0]        r_db_cnt;
    logic [CNT_W-1:0]       r_timer;
    logic [1:0]             r_state, w_next, r_from;
    logic [MAX_SYMBOLS-1:0] r_bits, r_out_bits;
    logic [LEN_W-1:0]       r_len, r_out_len;
    logic                   r_ovf, r_out_ovf, r_out_valid, r_word_end, r_drop;

    logic w_db_toggle, w_rise, w_fall, w_short, w_dash;
    logic w_append, w_emit, w_word;
    logic [MAX_SYMBOLS-1:0] w_onehot;

    assign w_db_toggle = (r_sync2 != r_key_db) && (r_db_cnt == c_DB_LAST);
    assign w_rise      = w_db_toggle & ~r_key_db;
    assign w_fall      = w_db_toggle &  r_key_db;
    assign w_short     = (r_timer < c_MIN_M1);
    assign w_dash      = (r_timer >= c_DASH_M1);
    assign w_onehot    = MAX_SYMBOLS'(1) << r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_key_db <= 1'b0;
            r_db_cnt <= '0;
            r_timer  <= '0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_key_db) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_key_db <= ~r_key_db;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
            if (w_db_toggle)
                r_timer <= '0;
            else if (r_timer != '1)
                r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_rise) w_next = c_PRESS;
            c_PRESS: if (w_fall) w_next = w_short ? r_from : c_GAP;
            c_GAP: begin
                if (w_rise)                    w_next = c_PRESS;
                else if (r_timer == c_CHAR_M1) w_next = c_SPACE;
            end
            default: begin
                if (w_rise)                    w_next = c_PRESS;
                else if (r_timer == c_WORD_M1) w_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_append = 1'b0;
        w_emit   = 1'b0;
        w_word   = 1'b0;
        case (r_state)
            c_PRESS: w_append = w_fall & ~w_short;
            c_GAP:   w_emit   = ~w_rise & (r_timer == c_CHAR_M1);
            c_SPACE: w_word   = ~w_rise & (r_timer == c_WORD_M1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_from      <= c_IDLE;
            r_bits      <= '0;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_len   <= '0;
            r_out_ovf   <= 1'b0;
            r_word_end  <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            // A glitch returns to whichever state the press interrupted.
            if (w_rise && r_state != c_PRESS)
                r_from <= r_state;
            if (w_append) begin
                if (r_len == c_LEN_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_bits <= r_bits | (w_dash ? w_onehot : '0);
                    r_len  <= r_len + 1'b1;
                end
            end
            if (w_emit) begin
                r_bits <= '0;
                r_len  <= '0;
                r_ovf  <= 1'b0;
            end
            r_word_end <= w_word;
            r_drop     <= w_emit & r_out_valid & ~bus.char_ready;
            if (w_emit && (!r_out_valid || bus.char_ready)) begin
                r_out_valid <= 1'b1;
                r_out_bits  <= r_bits;
                r_out_len   <= r_len;
                r_out_ovf   <= r_ovf;
            end else if (r_out_valid && bus.char_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.char_valid = r_out_valid;
    assign bus.char_bits  = r_out_bits;
    assign bus.char_len   = r_out_len;
    assign bus.char_ovf   = r_out_ovf;
    assign bus.word_end   = r_word_end;
    assign bus.drop       = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_morse_symbol_capture
//  Purpose  : Directed table-driven bench for morse_symbol_capture.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_symbol_capture;
    logic clk = 1'b0;
    logic rst;
    logic button;
    int   cyc = 0;

    morse_symbol_capture_if #(.MAX_SYMBOLS(4)) bus ();

    morse_symbol_capture #(
        .MAX_SYMBOLS(4), .DEBOUNCE(2), .MIN_PRESS(3), .DASH_MIN(20),
        .CHAR_GAP(30), .WORD_GAP(70), .CNT_W(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] bits;
        logic [2:0] len;
        logic       ovf;
    } char_t;

    typedef struct {
        int              n;
        logic [5:0][7:0] p;
        int              gap;
        int              en;
        logic [3:0]      bits;
        logic [2:0]      len;
        logic            ovf;
    } vec_t;

    // Monitor: accepted characters, valid rise time, word_end and drop pulses.
    char_t caps[$];
    int    n_word = 0, last_word = -1, n_drop = 0, last_rise = -1;
    logic  prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.char_valid && bus.char_ready)
                caps.push_back(char_t'({bus.char_bits, bus.char_len, bus.char_ovf}));
            if (bus.char_valid && !prev_valid) last_rise = cyc;
            if (bus.word_end) begin n_word++; last_word = cyc; end
            if (bus.drop) n_drop++;
        end
        prev_valid = bus.char_valid;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int pk(input logic [3:0] b, input logic [2:0] l, input logic o);
        return int'({b, l, o});
    endfunction

    function automatic vec_t mk(input int n, input int a, input int b, input int c,
                                input int d, input int e, input int f, input int en,
                                input logic [3:0] eb, input logic [2:0] el, input logic eo);
        vec_t v;
        v.n = n; v.gap = 10; v.en = en; v.bits = eb; v.len = el; v.ovf = eo;
        v.p[0] = 8'(a); v.p[1] = 8'(b); v.p[2] = 8'(c);
        v.p[3] = 8'(d); v.p[4] = 8'(e); v.p[5] = 8'(f);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input int n);
        button = 1'b1; tick(n); button = 1'b0;
    endtask

    task automatic do_reset();
        button = 1'b0; bus.char_ready = 1'b1; rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    function automatic int outs();
        return int'({bus.char_valid, bus.char_bits, bus.char_len, bus.char_ovf,
                     bus.word_end, bus.drop});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vec[9];
    int   b_caps, b_word, b_drop, rel;

    initial begin
        rst = 1'b1; button = 1'b0; bus.char_ready = 1'b1;
        //               n  presses               en bits     len   ovf
        vec[0] = mk(3, 10, 10, 40, 0, 0, 0,     1, 4'b0100, 3'd3, 1'b0);
        vec[1] = mk(1, 10,  0,  0, 0, 0, 0,     1, 4'b0000, 3'd1, 1'b0);
        vec[2] = mk(1, 25,  0,  0, 0, 0, 0,     1, 4'b0001, 3'd1, 1'b0);
        vec[3] = mk(1,  2,  0,  0, 0, 0, 0,     0, 4'b0000, 3'd0, 1'b0);
        vec[4] = mk(6, 10, 10, 10, 10, 10, 10,  1, 4'b0000, 3'd4, 1'b1);
        vec[5] = mk(3,  3, 19, 20, 0, 0, 0,     1, 4'b0100, 3'd3, 1'b0);
        vec[6] = mk(4, 20, 20, 20, 20, 0, 0,    1, 4'b1111, 3'd4, 1'b0);
        vec[7] = mk(3, 10,  2, 10, 0, 0, 0,     1, 4'b0000, 3'd2, 1'b0);
        vec[8] = mk(1,  1,  0,  0, 0, 0, 0,     0, 4'b0000, 3'd0, 1'b0);

        do_reset();
        chk("reset outputs", outs(), 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            b_caps = caps.size(); b_word = n_word;
            for (int k = 0; k < vec[i].n; k++) begin
                press(int'(vec[i].p[k]));
                if (k < vec[i].n - 1) tick(vec[i].gap);
            end
            rel = cyc;
            tick(110);
            chk($sformatf("v%0d nchars", i), caps.size() - b_caps, vec[i].en);
            chk($sformatf("v%0d word_end count", i), n_word - b_word, (vec[i].en > 0) ? 1 : 0);
            if (vec[i].en > 0 && caps.size() > b_caps) begin
                chk($sformatf("v%0d char", i), int'(caps[b_caps]),
                    pk(vec[i].bits, vec[i].len, vec[i].ovf));
                chk($sformatf("v%0d valid latency", i), last_rise - rel, 34);
                chk($sformatf("v%0d word_end latency", i), last_word - rel, 74);
            end
        end

        // Debounce filters a one-cycle raw blip: 10+1+10 = 21 cycles -> one dash.
        do_reset();
        b_caps = caps.size();
        press(10); tick(1); press(10);
        tick(110);
        chk("blip nchars", caps.size() - b_caps, 1);
        if (caps.size() > b_caps)
            chk("blip char", int'(caps[b_caps]), pk(4'b0001, 3'd1, 1'b0));

        // Overflow is confined to its own character.
        do_reset();
        b_caps = caps.size();
        for (int k = 0; k < 6; k++) begin press(10); tick(10); end
        tick(30);
        press(10);
        tick(110);
        chk("ovf nchars", caps.size() - b_caps, 2);
        if (caps.size() >= b_caps + 2) begin
            chk("ovf first", int'(caps[b_caps]), pk(4'b0000, 3'd4, 1'b1));
            chk("ovf second", int'(caps[b_caps + 1]), pk(4'b0000, 3'd1, 1'b0));
        end

        // Backpressure: E held, T dropped; then E accepted.
        do_reset();
        bus.char_ready = 1'b0;
        b_drop = n_drop;
        press(10); tick(40); press(25);
        tick(60);
        chk("bp E held valid", int'(bus.char_valid), 1);
        chk("bp E held data", pk(bus.char_bits, bus.char_len, bus.char_ovf), pk(4'b0000, 3'd1, 1'b0));
        chk("bp drop count", n_drop - b_drop, 1);
        bus.char_ready = 1'b1; tick(1); bus.char_ready = 1'b0;
        tick(2);
        chk("bp valid after accept", int'(bus.char_valid), 0);
        chk("bp accepted E", int'(caps[caps.size() - 1]), pk(4'b0000, 3'd1, 1'b0));
        tick(80);

        // Accept on T's emit edge: T replaces E without bubble or drop.
        b_drop = n_drop;
        press(10); tick(40); press(25);
        tick(33);
        bus.char_ready = 1'b1; tick(1); bus.char_ready = 1'b0;
        tick(3);
        chk("swap drop count", n_drop - b_drop, 0);
        chk("swap valid", int'(bus.char_valid), 1);
        chk("swap T data", pk(bus.char_bits, bus.char_len, bus.char_ovf), pk(4'b0001, 3'd1, 1'b0));
        chk("swap accepted E", int'(caps[caps.size() - 1]), pk(4'b0000, 3'd1, 1'b0));
        bus.char_ready = 1'b1; tick(2);
        chk("swap accepted T", int'(caps[caps.size() - 1]), pk(4'b0001, 3'd1, 1'b0));
        tick(100);

        // Reset mid-dash with two dots pending; key stays held through reset.
        do_reset();
        b_caps = caps.size();
        press(10); tick(10); press(10); tick(10);
        button = 1'b1; tick(15);
        rst = 1'b1; tick(1);
        chk("midreset outputs", outs(), 0);
        rst = 1'b0;
        tick(40); button = 1'b0;
        tick(110);
        chk("midreset nchars", caps.size() - b_caps, 1);
        if (caps.size() > b_caps)
            chk("midreset char", int'(caps[b_caps]), pk(4'b0001, 3'd1, 1'b0));

        // 50-cycle gap: two characters, one word_end after the second.
        do_reset();
        b_caps = caps.size(); b_word = n_word;
        press(10); tick(50); press(25);
        rel = cyc;
        tick(110);
        chk("gap50 nchars", caps.size() - b_caps, 2);
        chk("gap50 word_end count", n_word - b_word, 1);
        chk("gap50 word_end latency", last_word - rel, 74);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
